mask_pwm_modulator: RTL and testbench

- Parametrised M-ASK modulator. Splits each input word into symbols, MSB-first, and emits one PWM waveform per symbol period. Each duty level encodes one amplitude level.
- Generalises the fixed 4-ASK/8-bit PWM modulator:
  - configurable bits/symbol, symbols/word, PWM resolution and symbol rate;
  - symbol tick generated internally from the single system clock;
  - double-buffered valid/ready word input with underrun detection.
- Sits between the sampler/framing logic and the analog output pin, which drives the RC-filtered ASK line.

---
 rtl/mask_pwm_modulator_if.sv | 11 +
 rtl/mask_pwm_modulator.sv | 153 +++++++++++++++
 tb/tb_mask_pwm_modulator.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mask_pwm_modulator_if.sv
// Word handshake between the framing logic and the M-ASK PWM modulator.
interface mask_pwm_modulator_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/mask_pwm_modulator.sv
// M-ASK modulator: splits words into MSB-first symbols and emits one PWM duty level per symbol.
// Define GRAY_MAP_EN to treat each symbol field as Gray code before the duty lookup.
module mask_pwm_modulator #(
  parameter int unsigned BITS_PER_SYM  = 2,
  parameter int unsigned SYMS_PER_WORD = 4,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned SYM_DIV       = 62500,
  localparam int unsigned W    = BITS_PER_SYM * SYMS_PER_WORD,
  localparam int unsigned IdxW = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  mask_pwm_modulator_if.slave        word_bus,
  output logic                       pwm_out,
  output logic                       busy,
  output logic [IdxW-1:0]            sym_idx,
  output logic                       underrun
);
  localparam int unsigned L    = 1 << BITS_PER_SYM;
  localparam int unsigned P    = 1 << PWM_BITS;
  localparam int unsigned CntW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  if (SYM_DIV < P) begin : g_bad_sym_div
    $error("SYM_DIV must be at least 2**PWM_BITS");
  end
  if (BITS_PER_SYM < 1 || BITS_PER_SYM > 4) begin : g_bad_bits
    $error("BITS_PER_SYM must be in 1..4");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        shift_q, shift_d;
  logic [W-1:0]        hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [IdxW-1:0]     sym_idx_q, sym_idx_d;
  logic [CntW-1:0]     sym_cnt_q, sym_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_q, pwm_d;
  logic                underrun_q, underrun_d;
  logic                accept, load, sym_end, last_sym;

  logic [PWM_BITS-1:0]     duty_tbl [L];
  logic [BITS_PER_SYM-1:0] field, level;
  logic [PWM_BITS-1:0]     duty_cur;

  for (genvar k = 0; k < L; k++) begin : g_duty
    localparam int unsigned Duty = (L > 1) ? (k * (P - 1)) / (L - 1) : P - 1;
    assign duty_tbl[k] = PWM_BITS'(Duty);
  end

  assign field = shift_q[W-1 -: BITS_PER_SYM];

`ifdef GRAY_MAP_EN
  // Gray to binary: each bit is the XOR of all field bits at or above it.
  always_comb begin
    level = field;
    for (int s = 1; s < int'(BITS_PER_SYM); s++) begin
      level = level ^ (field >> s);
    end
  end
`else
  assign level = field;
`endif

  assign duty_cur = duty_tbl[level];
  assign sym_end  = (sym_cnt_q == CntW'(SYM_DIV - 1));
  assign last_sym = (sym_idx_q == IdxW'(SYMS_PER_WORD - 1));
  assign accept   = word_bus.word_valid && !hold_full_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    sym_idx_d  = sym_idx_q;
    sym_cnt_d  = sym_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    underrun_d = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q && enable) begin
          load      = 1'b1;
          state_d   = StRun;
          sym_idx_d = '0;
          sym_cnt_d = '0;
          pwm_cnt_d = '0;
        end
      end
      StRun: begin
        if (enable) begin
          if (sym_end) begin
            sym_cnt_d = '0;
            pwm_cnt_d = '0;
            if (!last_sym) begin
              shift_d   = shift_q << BITS_PER_SYM;
              sym_idx_d = sym_idx_q + 1'b1;
            end else if (hold_full_q) begin
              load      = 1'b1;
              sym_idx_d = '0;
            end else begin
              state_d    = StIdle;
              sym_idx_d  = '0;
              underrun_d = 1'b1;
            end
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d = hold_q;
    end
    hold_d      = accept ? word_bus.word_in : hold_q;
    hold_full_d = accept || (hold_full_q && !load);
    pwm_d       = (state_q == StRun) && enable && (pwm_cnt_q < duty_cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sym_idx_q   <= '0;
      sym_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      pwm_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sym_idx_q   <= sym_idx_d;
      sym_cnt_q   <= sym_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_q       <= pwm_d;
      underrun_q  <= underrun_d;
    end
  end

  assign word_bus.word_ready = !hold_full_q;
  assign pwm_out             = pwm_q;
  assign busy                = (state_q == StRun);
  assign sym_idx             = sym_idx_q;
  assign underrun            = underrun_q;
endmodule

// File: tb/tb_mask_pwm_modulator.sv
// Self-checking bench: per-symbol PWM high counts checked through a scoreboard on two instances.
module tb_mask_pwm_modulator;
  localparam int unsigned SymDivA = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable;
  logic       pwm_a, busy_a, und_a;
  logic [1:0] idx_a;
  logic       pwm_b, busy_b, und_b;
  logic [2:0] idx_b;

  mask_pwm_modulator_if #(.W(8)) bus_a ();
  mask_pwm_modulator_if #(.W(8)) bus_b ();

  mask_pwm_modulator #(
    .BITS_PER_SYM(2), .SYMS_PER_WORD(4), .PWM_BITS(8), .SYM_DIV(SymDivA)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .word_bus(bus_a),
    .pwm_out(pwm_a), .busy(busy_a), .sym_idx(idx_a), .underrun(und_a)
  );

  mask_pwm_modulator #(
    .BITS_PER_SYM(1), .SYMS_PER_WORD(8), .PWM_BITS(4), .SYM_DIV(20)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .word_bus(bus_b),
    .pwm_out(pwm_b), .busy(busy_b), .sym_idx(idx_b), .underrun(und_b)
  );

  typedef struct {
    logic [7:0] word;
    int         nat [4];
    int         gray [4];
  } vec_t;

  vec_t vecs [4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_q0 [$];
  int   exp_q1 [$];
  bit   mon_on = 1'b0;
  logic prev_busy [2] = '{1'b0, 1'b0};
  int   prev_idx [2] = '{0, 0};
  int   acc [2] = '{0, 0};
  int   und_cnt [2] = '{0, 0};
  int   busy_cnt [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic sb_compare(input int d, input int act);
    int exp;
    int sz;
    sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected dut%0d: got symbol high count %0d, required none", d, act);
    end else begin
      if (d == 0) exp = exp_q0.pop_front();
      else        exp = exp_q1.pop_front();
      check($sformatf("sym_high dut%0d", d), act, exp);
    end
  endtask

  // A pwm_out sample reflects the counters of the previous cycle, so it is credited
  // to the symbol context seen one negedge earlier.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic b, p, u;
      int   ix;
      b  = (d == 0) ? busy_a : busy_b;
      p  = (d == 0) ? pwm_a : pwm_b;
      u  = (d == 0) ? und_a : und_b;
      ix = (d == 0) ? int'(idx_a) : int'(idx_b);
      if (!mon_on) begin
        prev_busy[d] = 1'b0;
        acc[d]       = 0;
      end else begin
        if (u) und_cnt[d]++;
        if (b) busy_cnt[d]++;
        if (prev_busy[d] && p) acc[d]++;
        if (prev_busy[d] && (!b || ix != prev_idx[d])) begin
          sb_compare(d, acc[d]);
          acc[d] = 0;
        end
        prev_busy[d] = b;
        prev_idx[d]  = ix;
      end
    end
  end

  function automatic int exp_of(input int i, input int s);
`ifdef GRAY_MAP_EN
    return vecs[i].gray[s];
`else
    return vecs[i].nat[s];
`endif
  endfunction

  task automatic push_vec(input int i);
    for (int s = 0; s < 4; s++) exp_q0.push_back(exp_of(i, s));
  endtask

  task automatic send_a(input logic [7:0] w);
    int t = 0;
    while (!bus_a.word_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait_a", int'(bus_a.word_ready), 1);
    bus_a.word_in    = w;
    bus_a.word_valid = 1'b1;
    @(negedge clk);
    bus_a.word_valid = 1'b0;
    check("ready_low_after_accept_a", int'(bus_a.word_ready), 0);
  endtask

  task automatic wait_idle_a(input int budget);
    int t = 0;
    while ((busy_a || !bus_a.word_ready) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout_a", int'(t < budget), 1);
  endtask

  task automatic wait_idx_a(input int v, input int budget);
    int t = 0;
    while (int'(idx_a) != v && t < budget) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("sym_idx_wait_%0d", v), int'(idx_a), v);
  endtask

  initial begin
    int u0, b0, c0, c1, bad;
    vecs[0] = '{8'hE4, '{1020, 680, 340, 0}, '{680, 1020, 340, 0}};
    vecs[1] = '{8'h1B, '{0, 340, 680, 1020}, '{0, 340, 1020, 680}};
    vecs[2] = '{8'hFF, '{1020, 1020, 1020, 1020}, '{680, 680, 680, 680}};
    vecs[3] = '{8'h9C, '{680, 340, 1020, 0}, '{1020, 340, 680, 0}};

    rst              = 1'b1;
    enable           = 1'b1;
    bus_a.word_in    = '0;
    bus_a.word_valid = 1'b0;
    bus_b.word_in    = '0;
    bus_b.word_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;
    check("reset_pwm", int'(pwm_a), 0);
    check("reset_busy", int'(busy_a), 0);
    check("reset_ready", int'(bus_a.word_ready), 1);
    check("reset_sym_idx", int'(idx_a), 0);
    check("reset_underrun", int'(und_a), 0);

    // Single word, then underrun.
    u0 = und_cnt[0];
    b0 = busy_cnt[0];
    push_vec(0);
    send_a(vecs[0].word);
    wait_idle_a(6000);
    repeat (2) @(negedge clk);
    check("single_busy_cycles", busy_cnt[0] - b0, 4 * SymDivA);
    check("single_underrun_pulses", und_cnt[0] - u0, 1);

    // Back-to-back table: seamless reloads, one underrun at the very end.
    u0 = und_cnt[0];
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      push_vec(i);
      send_a(vecs[i].word);
      if (i == 0) c0 = cyc;
    end
    wait_idle_a(20000);
    check("b2b_elapsed_cycles", cyc - c0, 4 * 4 * SymDivA + 1);
    repeat (2) @(negedge clk);
    check("b2b_underrun_pulses", und_cnt[0] - u0, 1);

    // Enable pause in the middle of symbol 1.
    push_vec(0);
    send_a(vecs[0].word);
    wait_idx_a(1, 3000);
    c0 = cyc;
    repeat (500) @(negedge clk);
    enable = 1'b0;
    bad    = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_a !== 1'b0 || idx_a !== 2'd1) bad++;
    end
    enable = 1'b1;
    wait_idx_a(2, 3000);
    c1 = cyc;
    check("pause_bad_cycles", bad, 0);
    check("pause_symbol_len", c1 - c0, SymDivA + 300);
    wait_idle_a(6000);

    // Reset mid-word with a buffered word.
    send_a(8'hFF);
    send_a(8'hFF);
    repeat (200) @(negedge clk);
    check("pre_reset_hold_full", int'(bus_a.word_ready), 0);
    mon_on = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pwm", int'(pwm_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_ready", int'(bus_a.word_ready), 1);
    check("rst_sym_idx", int'(idx_a), 0);
    check("rst_underrun", int'(und_a), 0);
    mon_on = 1'b1;
    bad    = 0;
    repeat (5000) begin
      @(negedge clk);
      if (pwm_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    check("post_reset_activity", bad, 0);

    // Parameter sweep instance: 1 bit/symbol, partial last PWM period.
    u0 = und_cnt[1];
    b0 = busy_cnt[1];
    begin
      logic [7:0] w;
      int t;
      w = 8'hA5;
      for (int s = 7; s >= 0; s--) exp_q1.push_back(w[s] ? 19 : 0);
      bus_b.word_in    = w;
      bus_b.word_valid = 1'b1;
      @(negedge clk);
      bus_b.word_valid = 1'b0;
      t = 0;
      while ((busy_b || !bus_b.word_ready) && t < 1000) begin
        @(negedge clk);
        t++;
      end
      check("idle_timeout_b", int'(t < 1000), 1);
    end
    repeat (2) @(negedge clk);
    check("sweep_busy_cycles", busy_cnt[1] - b0, 160);
    check("sweep_underrun_pulses", und_cnt[1] - u0, 1);

    check("sb_left_a", exp_q0.size(), 0);
    check("sb_left_b", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
